// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory combinationally
// and captures the result into the IF/ID register, with stall, redirect/flush and halt.
module instr_fetch #(
  parameter int unsigned     AW       = 32,
  parameter int unsigned     DW       = 32,
  parameter logic [AW-1:0]   PC_RESET = AW'(32'd0),
  parameter logic [AW-1:0]   PC_LAST  = AW'(32'd1023),
  parameter int unsigned     CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_en,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] if_id_instr,
  output logic [AW-1:0] if_id_pc,
  output logic          if_id_valid,
  output logic          halted,
  output logic [CW-1:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_r, state_n_s;
  logic [AW-1:0] pc_r, pc_n_s;
  logic [DW-1:0] instr_r, instr_n_s;
  logic [AW-1:0] ipc_r, ipc_n_s;
  logic          valid_r, valid_n_s;
  logic          halted_r;
  logic [CW-1:0] count_r, count_n_s;

  // State and pipeline registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= PC_RESET;
      instr_r  <= {DW{1'b0}};
      ipc_r    <= {AW{1'b0}};
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= {CW{1'b0}};
    end else begin
      state_r  <= state_n_s;
      pc_r     <= pc_n_s;
      instr_r  <= instr_n_s;
      ipc_r    <= ipc_n_s;
      valid_r  <= valid_n_s;
      halted_r <= (state_n_s == HALT);
      count_r  <= count_n_s;
    end
  end

  // Next-state, PC and IF/ID update logic.
  always_comb begin
    state_n_s = state_r;
    pc_n_s    = pc_r;
    instr_n_s = instr_r;
    ipc_n_s   = ipc_r;
    valid_n_s = valid_r;
    count_n_s = count_r;
    case (state_r)
      IDLE: begin
        if (!stall) valid_n_s = 1'b0;
        else        valid_n_s = valid_r;
        if (redirect)      pc_n_s    = redirect_pc;
        else if (fetch_en) state_n_s = FETCH;
        else               state_n_s = IDLE;
      end
      FETCH: begin
        if (redirect) begin
          // Redirect beats a stall: the stalled instruction is discarded.
          pc_n_s    = redirect_pc;
          valid_n_s = 1'b0;
          if (redirect_pc > PC_LAST) state_n_s = HALT;
          else                       state_n_s = FETCH;
        end else if (!fetch_en) begin
          state_n_s = IDLE;
          if (!stall) valid_n_s = 1'b0;
          else        valid_n_s = valid_r;
        end else if (stall) begin
          valid_n_s = valid_r;
        end else begin
          instr_n_s = imem_data;
          ipc_n_s   = pc_r;
          valid_n_s = 1'b1;
          if (count_r != CNT_MAX) count_n_s = count_r + CNT_ONE;
          else                    count_n_s = count_r;
          if (pc_r == PC_LAST) state_n_s = HALT;
          else                 pc_n_s    = pc_r + PC_ONE;
        end
      end
      HALT: begin
        if (!stall) valid_n_s = 1'b0;
        else        valid_n_s = valid_r;
        if (redirect) begin
          pc_n_s = redirect_pc;
          if (redirect_pc > PC_LAST) begin
            state_n_s = HALT;
          end else begin
            state_n_s = FETCH;
            valid_n_s = 1'b0;
          end
        end else begin
          state_n_s = HALT;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_r;
  assign if_id_instr = instr_r;
  assign if_id_pc    = ipc_r;
  assign if_id_valid = valid_r;
  assign halted      = halted_r;
  assign fetch_count = count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected IF/ID snapshots are queued as each cycle
// is driven and compared one edge later. Small PC_LAST and CW exercise halt and saturation.
module tb_instr_fetch;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst;
  logic          fetch_en;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] if_id_instr;
  logic [AW-1:0] if_id_pc;
  logic          if_id_valid;
  logic          halted;
  logic [CW-1:0] fetch_count;

  logic [31:0] mem [0:15];

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cnt;
    logic        halt;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch #(
    .AW(AW), .DW(DW), .PC_RESET(32'd0), .PC_LAST(32'd12), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_data(imem_data), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  assign imem_data = (imem_addr < 32'd16) ? mem[imem_addr[3:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_reset_exp();
    e.valid = 1'b0; e.pc = 32'd0; e.instr = 32'd0;
    e.cnt = 4'd0; e.halt = 1'b0; e.addr = 32'd0;
  endtask

  // Expected effect of one latch of address a (pc then advances).
  task automatic latch_exp(input int a);
    e.valid = 1'b1;
    e.pc    = a;
    e.instr = mem[a];
    if (e.cnt != 4'hF) e.cnt = e.cnt + 4'd1;
    e.addr  = a + 1;
  endtask

  task automatic step(input logic r, input logic fe, input logic st,
                      input logic rd, input logic [31:0] rpc);
    exp_t x;
    rst = r; fetch_en = fe; stall = st; redirect = rd; redirect_pc = rpc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_eq("valid",  {31'd0, if_id_valid}, {31'd0, x.valid});
    check_eq("if_pc",  if_id_pc, x.pc);
    check_eq("instr",  if_id_instr, x.instr);
    check_eq("count",  {28'd0, fetch_count}, {28'd0, x.cnt});
    check_eq("halted", {31'd0, halted}, {31'd0, x.halt});
    check_eq("addr",   imem_addr, x.addr);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h2222_0000 + i;
    mem[0] = 32'h0000_0000; mem[1] = 32'h0503_1000; mem[2] = 32'h0000_0000;
    mem[3] = 32'h0043_0800; mem[5] = 32'h0901_F000; mem[10] = 32'h18E4_0001;
    rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    set_reset_exp();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    // IDLE -> FETCH edge latches nothing
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int a = 0; a < 6; a++) begin
      latch_exp(a);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    latch_exp(6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Redirect to 4, then redirect+stall to 10 while pc=4
    e.valid = 1'b0; e.addr = 32'd4;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd4);
    e.addr = 32'd10;
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'd10);
    for (int a = 10; a <= 12; a++) begin
      latch_exp(a);
      if (a == 12) begin e.addr = 32'd12; e.halt = 1'b1; end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    e.valid = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Resume from HALT at 3
    e.halt = 1'b0; e.addr = 32'd3;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd3);
    latch_exp(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Out-of-range redirect from FETCH
    e.valid = 1'b0; e.halt = 1'b1; e.addr = 32'd2000;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd2000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    e.halt = 1'b0; e.addr = 32'd4;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd4);
    // Run into count saturation (15)
    for (int a = 4; a <= 8; a++) begin
      latch_exp(a);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    e.valid = 1'b0; e.addr = 32'd6;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd6);
    latch_exp(6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // Reset mid-run at pc=7 overrides fetch/stall/redirect
    set_reset_exp();
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'd9);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    latch_exp(0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    // fetch_en drop -> IDLE, redirect in IDLE, restart
    e.valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    e.addr = 32'd5;
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    latch_exp(5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the word address into the memory's combinational read port. It captures the returned instruction into the IF/ID pipeline register and handles stall, branch redirect/flush and end-of-program halt. The instruction memory's write enable is tied low at the top level; this block only reads.

Parameters:
AW, 32, address/PC width (matches `ISIZE)
DW, 32, instruction width (matches `DSIZE)
PC_RESET, 0, PC value loaded on reset
PC_LAST, 1023, last fetchable word address (memory depth 32*`ISIZE minus 1)
CW, 16, width of the fetch counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
fetch_en  in  1  run enable from the top-level controller
stall  in  1  hold request from decode/hazard unit
redirect  in  1  branch taken / flush request
redirect_pc  in  AW  new PC when redirect=1
imem_addr  out  AW  word address to the instruction memory (= pc register, combinational)
imem_data  in  DW  instruction from the memory, same cycle as imem_addr
if_id_instr  out  DW  latched instruction
if_id_pc  out  AW  address of the latched instruction
if_id_valid  out  1  IF/ID register holds a real instruction
halted  out  1  high while in HALT
fetch_count  out  CW  number of instructions latched, saturating

Behaviour:
- Reset (rst=1 at posedge, overrides all other inputs, including mid-fetch):
  - pc=PC_RESET; if_id_instr=0; if_id_pc=0; if_id_valid=0; halted=0; fetch_count=0; state=IDLE.
  - The memory loads its contents on the same reset edges, so the first fetch after reset sees valid data.
- Addressing: word-addressed; next sequential PC is pc+1, with mod-2^AW wrap. imem_addr=pc at all times.
- States: IDLE, FETCH, HALT.
- IDLE:
  - pc is held.
  - If stall=0, if_id_valid<=0.
  - Moves to FETCH when fetch_en=1. No latch occurs on that edge; the first latch is on the following edge.
  - A redirect in IDLE loads pc<=redirect_pc and stays in IDLE.
- FETCH, priority order per edge:
  1. redirect=1:
     - pc<=redirect_pc and if_id_valid<=0 (flush). This holds even if stall=1.
     - If redirect_pc>PC_LAST, go to HALT; otherwise stay in FETCH.
  2. fetch_en=0:
     - Go to IDLE.
     - If stall=0, if_id_valid<=0.
     - pc is held.
  3. stall=1: pc, if_id_* and fetch_count all held.
  4. Otherwise:
     - if_id_instr<=imem_data; if_id_pc<=pc; if_id_valid<=1.
     - fetch_count increments, saturating at 2^CW-1.
     - If pc==PC_LAST, go to HALT and hold pc; else pc<=pc+1.
- HALT:
  - halted=1.
  - When stall=0, if_id_valid<=0, so the last instruction drains exactly once.
  - A redirect with redirect_pc<=PC_LAST goes to FETCH with pc<=redirect_pc, halted<=0, and flushes if_id_valid.
  - A redirect with redirect_pc>PC_LAST updates pc and stays in HALT.
- Latency: an instruction at address A appears in IF/ID one edge after pc==A with no stall, giving 1 instruction/cycle throughput.
- Stall+redirect on the same edge: redirect wins; the stalled instruction is discarded.
- fetch_count counts latches only; flushed instructions are not subtracted.

Test Plan:
- Sequential run: memory reset image loaded, rst for 2 cycles, fetch_en=1 -> after the IDLE->FETCH edge, consecutive cycles show (if_id_pc, if_id_instr) = (0,0x00000000), (1,0x05031000), (2,0x00000000), (3,0x00430800); fetch_count=4.
- Stall: assert stall for 3 cycles while if_id_pc=5 (0x0901F000) -> IF/ID, pc=6 and fetch_count frozen; the cycle after release shows if_id_pc=6.
- Redirect with flush: redirect=1, redirect_pc=10, together with stall=1 while pc=4 -> next cycle if_id_valid=0 and pc=10; the following edge gives if_id_instr=0x18E40001, if_id_pc=10.
- Halt: PC_LAST=12, run from 0 -> the latch of pc=12 is followed by halted=1; if_id_valid drops one cycle later; pc stays 12; a redirect to 3 resumes fetching with 0x00430800.
- Redirect out of range: redirect_pc=2000 in FETCH -> HALT, if_id_valid=0, no fetch_count change.
- Reset mid-run: rst asserted while in FETCH at pc=7 with if_id_valid=1 -> next edge all outputs take their reset values and state=IDLE; re-run starts at pc=0.
